// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// Synchronizes rx, waits for a start bit, samples every bit at its midpoint
// and presents the byte on data with a one-cycle rcv strobe and a framing flag.
module uart_rx #(
  parameter int BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       rcv,
  output logic [7:0] data,
  output logic       ferr
);

  // Counter width covers 0 .. BAUDRATE-1.
  localparam int            CW         = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] CNT_MID    = CW'(BAUDRATE / 2);
  localparam logic [3:0]    FRAME_BITS = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    LOAD = 2'd2,
    DAV  = 2'd3
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] baud_cnt;
  logic          baud_en;
  logic          tick;
  logic          armed;
  logic [9:0]    shift;
  logic [3:0]    bitc;

  // Two-flop synchronizer; both stages reset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep these as two distinct stages; blocking
      // would pass rx straight through to rx_s in a single clock.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Baud counter: runs 0..BAUDRATE-1 while receiving, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (!rstn || !baud_en) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  // Mid-bit sample strobe: half a bit into RECV, then once per bit period.
  assign tick = baud_en && (baud_cnt == CNT_MID);

  // Receive FSM together with the shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      baud_en <= 1'b0;
      armed   <= 1'b0;
      shift   <= 10'h3FF;
      bitc    <= 4'd0;
      rcv     <= 1'b0;
      data    <= 8'h00;
      ferr    <= 1'b0;
    end else begin
      rcv <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s && armed) begin
            state   <= RECV;
            baud_en <= 1'b1;
            bitc    <= 4'd0;
            armed   <= 1'b0;
          end else if (rx_s) begin
            // Only a high line re-arms, so a held-low line cannot restart a frame.
            armed <= 1'b1;
          end
        end
        RECV: begin
          if (bitc == FRAME_BITS) begin
            state   <= LOAD;
            baud_en <= 1'b0;
          end else if (tick) begin
            shift <= {rx_s, shift[9:1]};
            bitc  <= bitc + 4'd1;
            // A start bit that reads high at its midpoint was only a glitch.
            if (bitc == 4'd0 && rx_s) begin
              state   <= IDLE;
              baud_en <= 1'b0;
            end
          end
        end
        LOAD: begin
          data  <= shift[8:1];
          ferr  <= ~shift[9];
          rcv   <= 1'b1;
          state <= DAV;
        end
        DAV: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          baud_en <= 1'b0;
        end
      endcase
    end
  end

  // The strobe is a single-cycle pulse and the bit counter never passes a full frame.
  a_rcv_single : assert property (@(posedge clk) disable iff (!rstn) rcv |=> !rcv);
  a_bitc_range : assert property (@(posedge clk) disable iff (!rstn) bitc <= FRAME_BITS);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// A frame-level model predicts every received byte, its framing flag and the
// cycle its strobe appears; a monitor logs what the receiver actually delivers.
module tb_uart_rx;

  localparam int B = 16;
  // Start edge driven in cycle n0 -> strobe in cycle n0 + 3 + B/2 + 9*B + 3.
  localparam int RCV_LAT = 6 + B / 2 + 9 * B;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b1;
  logic       rcv;
  logic [7:0] data;
  logic       ferr;

  uart_rx #(.BAUDRATE(B)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .rcv  (rcv),
    .data (data),
    .ferr (ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int dbl_cnt = 0;
  int hold_cnt = 0;
  logic       prev_rcv  = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_ferr = 1'b0;

  // Monitor: log strobes, count back-to-back strobes and output changes without a strobe.
  always @(negedge clk) begin
    if (rcv === 1'b1) got_q.push_back('{data, ferr, cyc});
    if (rcv === 1'b1 && prev_rcv === 1'b1) dbl_cnt <= dbl_cnt + 1;
    if (rstn === 1'b1 && rcv !== 1'b1 && (data !== prev_data || ferr !== prev_ferr))
      hold_cnt <= hold_cnt + 1;
    prev_rcv  <= rcv;
    prev_data <= data;
    prev_ferr <= ferr;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame at exactly B cycles per bit and record what should come out.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    int         n0;
    f  = {stop, b, 1'b0};
    n0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      wait_cycles(B);
    end
    exp_q.push_back('{b, ~stop, n0 + RCV_LAT});
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    wait_cycles(5);
    rstn = 1'b1;
    exp_q.delete();
    got_q.delete();
    wait_cycles(200);
    n_cmp++; if (got_q.size() !== 0) begin n_mis++; $display("FAIL reset_rcv_count: got %0d pulses, expected 0", got_q.size()); end
    n_cmp++; if (rcv !== 1'b0) begin n_mis++; $display("FAIL reset_rcv: got %b, expected 0", rcv); end
    n_cmp++; if (data !== 8'h00) begin n_mis++; $display("FAIL reset_data: got %h, expected 00", data); end
    n_cmp++; if (ferr !== 1'b0) begin n_mis++; $display("FAIL reset_ferr: got %b, expected 0", ferr); end
  endtask

  task automatic test_single();
    exp_q.delete();
    got_q.delete();
    send_frame(8'h55, 1'b1);
    wait_cycles(20);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL single_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i].data !== exp_q[i].data) begin n_mis++; $display("FAIL single_data[%0d]: got %h, expected %h", i, got_q[i].data, exp_q[i].data); end
      n_cmp++; if (got_q[i].ferr !== exp_q[i].ferr) begin n_mis++; $display("FAIL single_ferr[%0d]: got %b, expected %b", i, got_q[i].ferr, exp_q[i].ferr); end
      n_cmp++; if (got_q[i].cyc !== exp_q[i].cyc) begin n_mis++; $display("FAIL single_time[%0d]: got cycle %0d, expected %0d", i, got_q[i].cyc, exp_q[i].cyc); end
    end
    n_cmp++; if (data !== 8'h55) begin n_mis++; $display("FAIL single_hold: got %h, expected 55", data); end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    got_q.delete();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    wait_cycles(20);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL b2b_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i].data !== exp_q[i].data) begin n_mis++; $display("FAIL b2b_data[%0d]: got %h, expected %h", i, got_q[i].data, exp_q[i].data); end
      n_cmp++; if (got_q[i].ferr !== exp_q[i].ferr) begin n_mis++; $display("FAIL b2b_ferr[%0d]: got %b, expected %b", i, got_q[i].ferr, exp_q[i].ferr); end
      n_cmp++; if (got_q[i].cyc !== exp_q[i].cyc) begin n_mis++; $display("FAIL b2b_time[%0d]: got cycle %0d, expected %0d", i, got_q[i].cyc, exp_q[i].cyc); end
    end
  endtask

  task automatic test_framing();
    logic [7:0] b;
    exp_q.delete();
    got_q.delete();
    send_frame(8'hFF, 1'b0);
    wait_cycles(40);
    rx = 1'b1;
    wait_cycles(30);
    n_cmp++; if (got_q.size() !== 1) begin n_mis++; $display("FAIL ferr_no_restart: got %0d pulses while line low/high, expected 1", got_q.size()); end
    b = 8'($urandom);
    send_frame(b, 1'b1);
    wait_cycles(20);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL ferr_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i].data !== exp_q[i].data) begin n_mis++; $display("FAIL ferr_data[%0d]: got %h, expected %h", i, got_q[i].data, exp_q[i].data); end
      n_cmp++; if (got_q[i].ferr !== exp_q[i].ferr) begin n_mis++; $display("FAIL ferr_flag[%0d]: got %b, expected %b", i, got_q[i].ferr, exp_q[i].ferr); end
      n_cmp++; if (got_q[i].cyc !== exp_q[i].cyc) begin n_mis++; $display("FAIL ferr_time[%0d]: got cycle %0d, expected %0d", i, got_q[i].cyc, exp_q[i].cyc); end
    end
  endtask

  task automatic test_glitch();
    exp_q.delete();
    got_q.delete();
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(40);
    n_cmp++; if (got_q.size() !== 0) begin n_mis++; $display("FAIL glitch_rcv: got %0d pulses, expected 0", got_q.size()); end
    send_frame(8'h3C, 1'b1);
    wait_cycles(20);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL glitch_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i].data !== exp_q[i].data) begin n_mis++; $display("FAIL glitch_data[%0d]: got %h, expected %h", i, got_q[i].data, exp_q[i].data); end
      n_cmp++; if (got_q[i].ferr !== exp_q[i].ferr) begin n_mis++; $display("FAIL glitch_ferr[%0d]: got %b, expected %b", i, got_q[i].ferr, exp_q[i].ferr); end
      n_cmp++; if (got_q[i].cyc !== exp_q[i].cyc) begin n_mis++; $display("FAIL glitch_time[%0d]: got cycle %0d, expected %0d", i, got_q[i].cyc, exp_q[i].cyc); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] v;
    v = 8'h81;
    exp_q.delete();
    got_q.delete();
    rx = 1'b0;
    wait_cycles(B);
    for (int i = 0; i < 4; i++) begin
      rx = v[i];
      wait_cycles(B);
    end
    rx = v[4];
    wait_cycles(B / 2);
    rstn = 1'b0;
    rx   = 1'b1;
    wait_cycles(3);
    rstn = 1'b1;
    n_cmp++; if (data !== 8'h00) begin n_mis++; $display("FAIL midrst_data: got %h, expected 00", data); end
    n_cmp++; if (ferr !== 1'b0) begin n_mis++; $display("FAIL midrst_ferr: got %b, expected 0", ferr); end
    wait_cycles(30);
    n_cmp++; if (got_q.size() !== 0) begin n_mis++; $display("FAIL midrst_rcv: got %0d pulses, expected 0", got_q.size()); end
    send_frame(8'h7E, 1'b1);
    wait_cycles(20);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL midrst_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i].data !== exp_q[i].data) begin n_mis++; $display("FAIL midrst_data[%0d]: got %h, expected %h", i, got_q[i].data, exp_q[i].data); end
      n_cmp++; if (got_q[i].cyc !== exp_q[i].cyc) begin n_mis++; $display("FAIL midrst_time[%0d]: got cycle %0d, expected %0d", i, got_q[i].cyc, exp_q[i].cyc); end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    int         gap;
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < 24; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      if (!stop) wait_cycles($urandom_range(0, 20));
      rx  = 1'b1;
      gap = stop ? $urandom_range(0, 8) : $urandom_range(2, 12);
      if (gap > 0) wait_cycles(gap);
    end
    wait_cycles(20);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL rand_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i].data !== exp_q[i].data) begin n_mis++; $display("FAIL rand_data[%0d]: got %h, expected %h", i, got_q[i].data, exp_q[i].data); end
      n_cmp++; if (got_q[i].ferr !== exp_q[i].ferr) begin n_mis++; $display("FAIL rand_ferr[%0d]: got %b, expected %b", i, got_q[i].ferr, exp_q[i].ferr); end
      n_cmp++; if (got_q[i].cyc !== exp_q[i].cyc) begin n_mis++; $display("FAIL rand_time[%0d]: got cycle %0d, expected %0d", i, got_q[i].cyc, exp_q[i].cyc); end
    end
    n_cmp++; if (dbl_cnt !== 0) begin n_mis++; $display("FAIL rcv_double: got %0d back-to-back strobes, expected 0", dbl_cnt); end
    n_cmp++; if (hold_cnt !== 0) begin n_mis++; $display("FAIL data_hold: got %0d output changes without rcv, expected 0", hold_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
